// File: rtl/hamming_2d_pkg.sv
// Shared constants and helpers for the 2D interleaved Hamming(15,11) code.
// Used by both encoder and decoder sides of the link.
package hamming_2d_pkg;

   localparam int unsigned HAM_N = 15;
   localparam int unsigned HAM_K = 11;

   // Check-bit positions 1,2,4,8 as a mask over bit j (position j+1)
   localparam logic [HAM_N-1:0] CHECK_MASK = 15'h008B;

   // Per-word decode outcome; the two flags are mutually exclusive
   typedef struct packed {
      logic corrected;
      logic uncorrectable;
   } dec_status_t;

   // Bus bit carrying Hamming bit j of row r
   function automatic int unsigned idx(input int unsigned j, input int unsigned r,
                                       input int unsigned rows);
      return j * (rows + 1) + r;
   endfunction

   // XOR of the 1-based positions of all set bits
   function automatic logic [3:0] syndrome(input logic [HAM_N-1:0] cw);
      logic [3:0] s;
      s = '0;
      for (int unsigned j = 0; j < HAM_N; j++) begin
         if (cw[4'(j)]) s = s ^ 4'(j + 1);
      end
      return s;
   endfunction

   // Data bits live at the non-check positions, ascending, LSB first
   function automatic logic [HAM_K-1:0] extract_data(input logic [HAM_N-1:0] cw);
      logic [HAM_K-1:0] d;
      logic [3:0]       k;
      d = '0;
      k = '0;
      for (int unsigned j = 0; j < HAM_N; j++) begin
         if (!CHECK_MASK[4'(j)]) begin
            d[k] = cw[4'(j)];
            k    = k + 4'd1;
         end
      end
      return d;
   endfunction

   // Bit (s-1) set; zero syndrome maps to no bit
   function automatic logic [HAM_N-1:0] onehot15(input logic [3:0] s);
      logic [HAM_N-1:0] o;
      o = '0;
      if (s != 4'd0) o[s - 4'd1] = 1'b1;
      return o;
   endfunction

endpackage

// File: rtl/hamming_2d_stream_decoder_if.sv
// Stream bus of the 2D Hamming decoder: codeword input side (s_*) and
// decoded payload output side (m_*) with valid/ready handshakes.
//   slave  : decoder view      master : upstream/downstream environment view
interface hamming_2d_stream_decoder_if #(
   parameter int unsigned ROWS = 4
) ();
   import hamming_2d_pkg::*;

   localparam int unsigned DW = ROWS * HAM_K;
   localparam int unsigned CW = (ROWS + 1) * HAM_N;

   logic            s_valid;
   logic            s_ready;
   logic [CW-1:0]   s_data;
   logic            m_valid;
   logic            m_ready;
   logic [DW-1:0]   m_data;
   logic            m_corrected;
   logic            m_uncorrectable;
   logic [ROWS-1:0] m_err_rows;

   modport slave (
      input  s_valid, s_data, m_ready,
      output s_ready, m_valid, m_data, m_corrected, m_uncorrectable, m_err_rows
   );

   modport master (
      output s_valid, s_data, m_ready,
      input  s_ready, m_valid, m_data, m_corrected, m_uncorrectable, m_err_rows
   );

endinterface

// File: rtl/hamming_15_11_row_check.sv
// Combinational syndrome and raw data extraction for one Hamming(15,11) row.
//   row_i    : received 15-bit row, bit j = position j+1
//   syn_c_o  : 4-bit syndrome
//   data_c_o : 11 uncorrected data bits
module hamming_15_11_row_check
   import hamming_2d_pkg::*;
(
   input  logic [HAM_N-1:0] row_i,
   output logic [3:0]       syn_c_o,
   output logic [HAM_K-1:0] data_c_o
);

   assign syn_c_o  = syndrome(row_i);
   assign data_c_o = extract_data(row_i);

endmodule

// File: rtl/hamming_2d_stream_decoder.sv
// Two-stage streaming decoder for the 2D interleaved Hamming code.
// Stage 1 de-interleaves and computes row syndromes and column mismatch;
// stage 2 cross-checks them, corrects, and registers payload and flags.
//   clk, rst_n   : clock, async active-low reset
//   bus          : s_* codeword stream in, m_* payload stream out
//   cnt_clear    : synchronous clear of both statistics counters
//   corr_count   : saturating count of corrected words delivered
//   uncorr_count : saturating count of uncorrectable words delivered
module hamming_2d_stream_decoder
   import hamming_2d_pkg::*;
#(
   parameter int unsigned ROWS  = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   hamming_2d_stream_decoder_if.slave  bus,
   input  logic                        cnt_clear,
   output logic [CNT_W-1:0]            corr_count,
   output logic [CNT_W-1:0]            uncorr_count
);

   localparam int unsigned NR = ROWS + 1;

   logic                        en1_c;
   logic                        en2_c;
   logic [ROWS-1:0][HAM_N-1:0]  row_c;
   logic [ROWS-1:0][3:0]        syn_c;
   logic [ROWS-1:0][HAM_K-1:0]  dat_c;
   logic [HAM_N-1:0]            e_c;

   logic                        v1_q;
   logic [ROWS-1:0][3:0]        syn_q;
   logic [ROWS-1:0][HAM_K-1:0]  dat_q;
   logic [HAM_N-1:0]            e_q;

   logic [ROWS-1:0][HAM_N-1:0]  oh_c;
   logic [HAM_N-1:0][ROWS-1:0]  oh_t_c;
   logic [ROWS-1:0][HAM_K-1:0]  fix_c;
   logic [HAM_N-1:0]            x_c;
   logic [ROWS-1:0]             err_rows_c;
   logic                        match_c;
   logic                        single_c;
   dec_status_t                 st_c;
   logic [ROWS-1:0][HAM_K-1:0]  pay_c;

   logic                        v2_q;
   logic [ROWS-1:0][HAM_K-1:0]  pay_q;
   dec_status_t                 st_q;
   logic [ROWS-1:0]             err_rows_q;

   logic                        xfer_c;
   logic [CNT_W-1:0]            corr_cnt_d, corr_cnt_q;
   logic [CNT_W-1:0]            uncorr_cnt_d, uncorr_cnt_q;

   // Pipeline enables: a stage advances when empty or when its successor does
   assign en2_c       = !v2_q || bus.m_ready;
   assign en1_c       = !v1_q || en2_c;
   assign bus.s_ready = en1_c;

   // De-interleave data rows and check each one
   for (genvar r = 0; r < ROWS; r++) begin : g_row
      for (genvar j = 0; j < HAM_N; j++) begin : g_bit
         assign row_c[r][j] = bus.s_data[idx(j, r, ROWS)];
      end
      hamming_15_11_row_check u_chk (
         .row_i    (row_c[r]),
         .syn_c_o  (syn_c[r]),
         .data_c_o (dat_c[r])
      );
   end

   // All rows of one position are adjacent on the bus, so E is a slice XOR
   for (genvar j = 0; j < HAM_N; j++) begin : g_col
      assign e_c[j] = ^bus.s_data[j*NR +: NR];
   end

   // Stage 1: keep only data bits; check bits matter only through S_r and E
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q  <= 1'b0;
         syn_q <= '0;
         dat_q <= '0;
         e_q   <= '0;
      end else if (en1_c) begin
         v1_q <= bus.s_valid;
         if (bus.s_valid) begin
            syn_q <= syn_c;
            dat_q <= dat_c;
            e_q   <= e_c;
         end
      end
   end

   // Per-row correction candidates and the column mismatch they predict
   for (genvar r = 0; r < ROWS; r++) begin : g_fix
      assign oh_c[r]       = onehot15(syn_q[r]);
      assign err_rows_c[r] = |syn_q[r];
      // Flipping a check position leaves the data bits untouched
      assign fix_c[r]      = dat_q[r] ^ extract_data(oh_c[r]);
      for (genvar j = 0; j < HAM_N; j++) begin : g_t
         assign oh_t_c[j][r] = oh_c[r][j];
      end
   end

   for (genvar j = 0; j < HAM_N; j++) begin : g_x
      assign x_c[j] = ^oh_t_c[j];
   end

   assign match_c  = (e_q == x_c);
   assign single_c = (e_q != '0) && ((e_q & (e_q - 15'd1)) == '0);

   // Decision: agreement of E with X covers both clean and correctable words
   always_comb begin
      st_c  = '0;
      pay_c = dat_q;
      if (match_c) begin
         st_c.corrected = |err_rows_c;
         pay_c          = fix_c;
      end else if ((err_rows_c == '0) && single_c) begin
         st_c.corrected = 1'b1;
      end else begin
         st_c.uncorrectable = 1'b1;
      end
   end

   // Stage 2: output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2_q       <= 1'b0;
         pay_q      <= '0;
         st_q       <= '0;
         err_rows_q <= '0;
      end else if (en2_c) begin
         v2_q <= v1_q;
         if (v1_q) begin
            pay_q      <= pay_c;
            st_q       <= st_c;
            err_rows_q <= err_rows_c;
         end
      end
   end

   assign bus.m_valid         = v2_q;
   assign bus.m_data          = pay_q;
   assign bus.m_corrected     = st_q.corrected;
   assign bus.m_uncorrectable = st_q.uncorrectable;
   assign bus.m_err_rows      = err_rows_q;

   // Saturating statistics; clear takes priority over a same-cycle transfer
   assign xfer_c = v2_q && bus.m_ready;

   always_comb begin
      corr_cnt_d   = corr_cnt_q;
      uncorr_cnt_d = uncorr_cnt_q;
      if (cnt_clear) begin
         corr_cnt_d   = '0;
         uncorr_cnt_d = '0;
      end else if (xfer_c) begin
         if (st_q.corrected && (corr_cnt_q != '1))
            corr_cnt_d = corr_cnt_q + CNT_W'(1);
         if (st_q.uncorrectable && (uncorr_cnt_q != '1))
            uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         corr_cnt_q   <= '0;
         uncorr_cnt_q <= '0;
      end else begin
         corr_cnt_q   <= corr_cnt_d;
         uncorr_cnt_q <= uncorr_cnt_d;
      end
   end

   assign corr_count   = corr_cnt_q;
   assign uncorr_count = uncorr_cnt_q;

endmodule

// File: doc/hamming_2d_stream_decoder.md
Name: hamming_2d_stream_decoder

Overview:
Streaming, pipelined decoder for the 2D interleaved Hamming code, parametrised in row count ROWS. Each word holds ROWS Hamming(15,11) rows plus one column-parity row, column-interleaved across the bus. It corrects one error per row using the row syndromes cross-checked against the column parity, and flags uncorrectable words. Valid/ready handshake on both sides, with saturating error-statistics counters. Sits on the receive side, downstream of the channel and upstream of the payload consumer.

Parameters:
ROWS, 4, number of Hamming(15,11) data rows (>=1)
CNT_W, 16, width of each statistics counter
(derived localparams) DW = ROWS*11 payload width; CW = (ROWS+1)*15 codeword width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  input codeword valid
s_ready  out  1  decoder can accept
s_data  in  CW  received interleaved codeword
m_valid  out  1  output valid
m_ready  in  1  consumer accepts
m_data  out  DW  decoded payload, row r at [r*11 +: 11]
m_corrected  out  1  word had errors, all corrected
m_uncorrectable  out  1  word failed consistency check
m_err_rows  out  ROWS  rows with nonzero syndrome
cnt_clear  in  1  synchronous clear of both counters
corr_count  out  CNT_W  words transferred with m_corrected=1
uncorr_count  out  CNT_W  words transferred with m_uncorrectable=1

Behaviour:
- Layout: row r (r=0..ROWS-1 data, r=ROWS parity row), bit j (j=0..14 means Hamming position j+1) sits at s_data[j*(ROWS+1)+r].
- Check bits sit at positions 1,2,4,8. Data bits sit at the remaining positions in ascending order, LSB first.
- Parity row = bitwise XOR of all data-row codewords. The parity row has no Hamming protection.
- Row syndrome: S_r = XOR of (position index) over the set bits of row r, 4 bits.
- Column mismatch: E = XOR of all ROWS+1 rows, 15 bits. F = {r : S_r != 0}.
- Expected mismatch: X = XOR over r in F of onehot(S_r-1).
- Decision rules:
  - F empty, E==0: clean.
  - F empty, popcount(E)==1: parity-row error. Payload untouched, corrected=1.
  - F empty, popcount(E)>1: uncorrectable.
  - F nonempty, E==X: flip bit S_r-1 of every row in F, corrected=1.
  - F nonempty, E!=X: uncorrectable. Payload is the raw, uncorrected data bits.
- m_corrected and m_uncorrectable are never both 1.
- Pipeline, 2 stages:
  - Stage 1 registers the de-interleaved rows, S_r and E.
  - Stage 2 registers the corrected payload and the flags.
  - Latency is 2 cycles from the s_valid&&s_ready edge to m_valid.
- Flow control:
  - en2 = !v2 || m_ready; en1 = !v1 || en2; s_ready = en1.
  - Full throughput is 1 word/cycle.
  - A stalled stage holds its data stable. No drop, duplication or reorder.
- m_valid must not drop while m_ready is low, and m_data and the flags stay stable while it is held.
- Counters:
  - A counter increments on m_valid&&m_ready when the matching flag is set.
  - Each counter saturates at all-ones.
  - cnt_clear zeroes both counters. A transfer in the same cycle is not counted (clear wins).
- Reset (async, rst_n=0):
  - v1, v2, m_valid, flags, m_err_rows, m_data and both counters go to 0.
  - s_ready reads 1 while in reset.
  - Words in flight are discarded.
- No configuration or state beyond the pipeline and the counters.

Decomposition:
- Package hamming_2d_pkg holds:
  - Constants HAM_N=15, HAM_K=11 and the parity-position list.
  - Functions: syndrome(15b), extract_data(15b)->11b, onehot15(4b).
  - The interleave index function idx(j,r,rows).
- Encoder and decoder share the package.
- Sub-module hamming_15_11_row_check: combinational syndrome plus data extraction for one row, instantiated ROWS times in stage 1.

Test Plan:
- Clean traffic: ROWS=4, payload 44'hA5A_5A5A_5A5A encoded by the bench model, m_ready=1. Expect m_data identical 2 cycles later, both flags 0, m_err_rows=0, counters 0.
- Single error: flip s_data[32] (row 2, position 7). Expect m_data restored, m_corrected=1, m_err_rows=4'b0100, corr_count=1.
- Double error in one row: flip row 1 positions 3 and 5 (s_data[11], s_data[21]). S_1=6 and E has bits 2,4, so E!=X. Expect m_uncorrectable=1, m_err_rows=4'b0010, raw payload out, uncorr_count=1.
- Parity-row error: flip s_data[19] (row 4, j=3). Expect payload unchanged, m_corrected=1, m_err_rows=0.
- Backpressure: stream 6 words, hold m_ready=0 for 5 cycles. Expect s_ready low after 2 accepts, then all 6 delivered in order with no duplicates and m_data stable while stalled.
- Counters and reset: CNT_W=2, 5 single-error words, expect corr_count saturating at 3. cnt_clear together with a corrected transfer gives 0. rst_n low mid-stream clears m_valid immediately and no stale word appears afterwards.
